// File: rtl/bcd_parity_sequencer.sv
// bcd_parity_sequencer: control stage for an even/odd BCD counter.
// Keeps a shadow BCD digit, computes the next digit of the selected parity
// sequence, and drives registered per-bit set/reset excitations into a
// negedge-clocked SR flip-flop bank. Also flags terminal count, counts wraps,
// and keeps a sticky error flag.
// Optional build macro FB_CHECK_EN: when defined, the SR bank's q outputs
// (q_fb) are compared against the shadow count on every posedge, except the
// first posedge after reset release. When undefined, q_fb is unused and err
// is set only by invalid loads.
module bcd_parity_sequencer #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [3:0]        load_val,
  input  logic [3:0]        q_fb,
  output logic [3:0]        s,
  output logic [3:0]        r,
  output logic [3:0]        count,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err
);

  localparam int unsigned DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] TOP_EVEN  = DIGIT_W'(8);

  logic [DIGIT_W-1:0] count_q, count_d;
  logic [DIGIT_W-1:0] s_q, s_d;
  logic [DIGIT_W-1:0] r_q, r_d;
  logic               tc_q, tc_d;
  logic [WRAP_W-1:0]  wrap_q, wrap_d;
  logic               err_q, err_d;
  logic [DIGIT_W-1:0] step_nxt_c;
  logic               fb_bad_c;

  // Next digit of the parity sequence, or the catch-up step on a mismatch.
  always_comb begin
    step_nxt_c = count_q;
    if (count_q[0] == mode) begin
      if (count_q == TOP_EVEN)       step_nxt_c = DIGIT_W'(0);
      else if (count_q == MAX_DIGIT) step_nxt_c = DIGIT_W'(1);
      else                           step_nxt_c = count_q + DIGIT_W'(2);
    end else begin
      if (count_q == MAX_DIGIT)      step_nxt_c = DIGIT_W'(0);
      else                           step_nxt_c = count_q + DIGIT_W'(1);
    end
  end

`ifdef FB_CHECK_EN
  logic first_q;

  // Suppresses the feedback compare on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) first_q <= 1'b1;
    else      first_q <= 1'b0;
  end

  // Bank readback disagrees with the shadow count it should mirror.
  always_comb begin
    fb_bad_c = 1'b0;
    if (!first_q && (q_fb != count_q)) fb_bad_c = 1'b1;
  end
`else
  logic unused_fb;

  // Feedback is ignored in this build.
  always_comb begin
    fb_bad_c  = 1'b0;
    unused_fb = ^q_fb;
  end
`endif

  // Load/step/hold selection, excitation encoding, tc, wrap and error update.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    err_d   = err_q;
    if (load) begin
      if (load_val <= MAX_DIGIT) count_d = load_val;
      else                       err_d   = 1'b1;
    end else if (en) begin
      count_d = step_nxt_c;
      tc_d    = (step_nxt_c < count_q);
    end
    if (fb_bad_c) err_d = 1'b1;
    // Unchanged bits get 00, the SR hold code; set/reset never overlap.
    s_d    = count_d & ~count_q;
    r_d    = ~count_d & count_q;
    wrap_d = wrap_q + WRAP_W'(tc_d);
  end

  // Register all state and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      s_q     <= '0;
      r_q     <= '0;
      tc_q    <= 1'b0;
      wrap_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      s_q     <= s_d;
      r_q     <= r_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count    = count_q;
  assign s        = s_q;
  assign r        = r_q;
  assign tc       = tc_q;
  assign wrap_cnt = wrap_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bcd_parity_sequencer.sv
// Directed testbench for bcd_parity_sequencer with a behavioural SR bank
// model on the negedge feeding q_fb back to the design.
module tb_bcd_parity_sequencer;

  localparam int unsigned WRAP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en, mode, load;
  logic [3:0]        load_val;
  logic [3:0]        q_fb;
  logic [3:0]        s, r, count;
  logic              tc;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              err;

  logic [3:0] bank_q;
  logic [3:0] fault_mask;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

`ifdef FB_CHECK_EN
  localparam logic FB_ERR_EXP = 1'b1;
`else
  localparam logic FB_ERR_EXP = 1'b0;
`endif

  bcd_parity_sequencer #(.WRAP_W(WRAP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q_fb     (q_fb),
    .s        (s),
    .r        (r),
    .count    (count),
    .tc       (tc),
    .wrap_cnt (wrap_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Negedge SR bank sharing the async reset.
  always @(negedge clk or negedge rst) begin
    if (!rst) bank_q <= 4'b0000;
    else begin
      for (int i = 0; i < 4; i++) begin
        if (s[i])      bank_q[i] <= 1'b1;
        else if (r[i]) bank_q[i] <= 1'b0;
      end
    end
  end

  assign q_fb = bank_q ^ fault_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the posedge.
  task automatic cyc(input logic e, input logic m, input logic l, input logic [3:0] lv);
    en = e; mode = m; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] c, input logic [3:0] sx,
                         input logic [3:0] rx, input logic t);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".s"},     32'(s),     32'(sx));
    check({tag, ".r"},     32'(r),     32'(rx));
    check({tag, ".tc"},    32'(tc),    32'(t));
  endtask

  task automatic chk_zero(input string tag);
    chk_out(tag, 4'd0, 4'b0000, 4'b0000, 1'b0);
    check({tag, ".wrap"}, 32'(wrap_cnt), 32'd0);
    check({tag, ".err"},  32'(err),      32'd0);
  endtask

  // Async reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    chk_zero("rst_async");
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; load_val = 4'd0;
    fault_mask = 4'b0000;
    #2;
    chk_zero("por");
    #5;
    rst = 1'b1;

    // Even sequence: 0->2->4->6->8->0->2
    cyc(1, 0, 0, 0); chk_out("ev1", 4'd2, 4'b0010, 4'b0000, 0);
    cyc(1, 0, 0, 0); chk_out("ev2", 4'd4, 4'b0100, 4'b0010, 0);
    cyc(1, 0, 0, 0); chk_out("ev3", 4'd6, 4'b0010, 4'b0000, 0);
    cyc(1, 0, 0, 0); chk_out("ev4", 4'd8, 4'b1000, 4'b0110, 0);
    cyc(1, 0, 0, 0); chk_out("ev5", 4'd0, 4'b0000, 4'b1000, 1);
    check("ev5.wrap", 32'(wrap_cnt), 32'd1);
    cyc(1, 0, 0, 0); chk_out("ev6", 4'd2, 4'b0010, 4'b0000, 0);
    check("ev6.wrap", 32'(wrap_cnt), 32'd1);
    // Hold
    cyc(0, 0, 0, 0); chk_out("hold", 4'd2, 4'b0000, 4'b0000, 0);
    check("hold.err", 32'(err), 32'd0);

    // Odd sequence from reset: 0->1->3->5->7->9->1
    do_reset();
    cyc(1, 1, 0, 0); chk_out("od1", 4'd1, 4'b0001, 4'b0000, 0);
    cyc(1, 1, 0, 0); chk_out("od2", 4'd3, 4'b0010, 4'b0000, 0);
    cyc(1, 1, 0, 0); chk_out("od3", 4'd5, 4'b0100, 4'b0010, 0);
    cyc(1, 1, 0, 0); chk_out("od4", 4'd7, 4'b0010, 4'b0000, 0);
    cyc(1, 1, 0, 0); chk_out("od5", 4'd9, 4'b1000, 4'b0110, 0);
    cyc(1, 1, 0, 0); chk_out("od6", 4'd1, 4'b0000, 4'b1000, 1);
    check("od6.wrap", 32'(wrap_cnt), 32'd1);

    // Mode switching: load 4, odd mode -> 5,7,9; even mode 9->0 (tc), 2
    cyc(0, 1, 1, 4'd4); chk_out("ld4", 4'd4, 4'b0100, 4'b0001, 0);
    cyc(1, 1, 0, 0);    chk_out("ms1", 4'd5, 4'b0001, 4'b0000, 0);
    cyc(1, 1, 0, 0);    chk_out("ms2", 4'd7, 4'b0010, 4'b0000, 0);
    cyc(1, 1, 0, 0);    chk_out("ms3", 4'd9, 4'b1000, 4'b0110, 0);
    cyc(1, 0, 0, 0);    chk_out("ms4", 4'd0, 4'b0000, 4'b1001, 1);
    check("ms4.wrap", 32'(wrap_cnt), 32'd2);
    cyc(1, 0, 0, 0);    chk_out("ms5", 4'd2, 4'b0010, 4'b0000, 0);
    // Load of a lower value with en never raises tc
    cyc(1, 0, 1, 4'd1); chk_out("ldlo", 4'd1, 4'b0001, 4'b0010, 0);
    check("ldlo.wrap", 32'(wrap_cnt), 32'd2);

    // Load beats en; invalid load holds and sets sticky err
    do_reset();
    cyc(1, 0, 1, 4'd7);  chk_out("ld7", 4'd7, 4'b0111, 4'b0000, 0);
    check("ld7.err", 32'(err), 32'd0);
    cyc(1, 0, 1, 4'd12); chk_out("ldbad", 4'd7, 4'b0000, 4'b0000, 0);
    check("ldbad.err", 32'(err), 32'd1);
    cyc(1, 1, 0, 0);     chk_out("postbad", 4'd9, 4'b1000, 4'b0110, 0);
    check("postbad.err", 32'(err), 32'd1);
    cyc(0, 1, 0, 0);     check("sticky.err", 32'(err), 32'd1);

    // Feedback fault on bit 2 for one cycle
    do_reset();
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    check("fb_pre.count", 32'(count), 32'd4);
    check("fb_pre.err", 32'(err), 32'd0);
    fault_mask = 4'b0100;
    cyc(0, 0, 0, 0);
    fault_mask = 4'b0000;
    check("fb_fault.err", 32'(err), 32'(FB_ERR_EXP));
    cyc(0, 0, 0, 0);
    check("fb_post.err", 32'(err), 32'(FB_ERR_EXP));

    // Mid-operation async reset with all outputs non-zero beforehand
    do_reset();
    cyc(0, 0, 1, 4'd15);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("mid.tc", 32'(tc), 32'd1);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk_out("mid6", 4'd6, 4'b0010, 4'b0000, 0);
    check("mid6.wrap", 32'(wrap_cnt), 32'd1);
    check("mid6.err", 32'(err), 32'd1);
    do_reset();
    cyc(1, 0, 0, 0); chk_out("restart", 4'd2, 4'b0010, 4'b0000, 0);
    check("restart.wrap", 32'(wrap_cnt), 32'd0);
    check("restart.err", 32'(err), 32'd0);
    cyc(1, 0, 0, 0); chk_out("restart2", 4'd4, 4'b0100, 4'b0010, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bcd_parity_sequencer.md
# bcd_parity_sequencer

Upstream control stage for the even/odd BCD counter. It holds a shadow copy of the current BCD digit and computes the next digit in the selected parity sequence. It drives registered per-bit set/reset excitations into the 4-bit bank of negedge-clocked SR flip-flops. It also flags terminal count, counts wraps, and optionally checks the bank's q outputs against the shadow count.

## Interface
- WRAP_W, 8, width of the wrap counter
- clk  input  1  clock; this block registers on posedge, the SR bank samples on the following negedge
- rst  input  1  asynchronous, active-low reset; shared with the SR bank
- en  input  1  advance one step this cycle
- mode  input  1  0 = even sequence, 1 = odd sequence
- load  input  1  synchronous load of load_val; priority over en
- load_val  input  4  BCD value to load
- q_fb  input  4  q outputs of the SR bank, bit i from flop i
- s  output  4  set excitation to SR flop i
- r  output  4  reset excitation to SR flop i
- count  output  4  shadow BCD count
- tc  output  1  one-cycle terminal-count pulse
- wrap_cnt  output  WRAP_W  number of tc pulses, modulo 2^WRAP_W
- err  output  1  sticky error flag

## Operation
- Reset values: s=0, r=0, count=0, tc=0, wrap_cnt=0, err=0. The SR bank also resets to 0, so the block and the bank agree out of reset.
- Next-value rules, when en=1 and load=0:
  - Parity of count matches mode: even sequence 0→2→4→6→8→0; odd sequence 1→3→5→7→9→1.
  - Parity mismatch (after a mode change or a load): next = count+1, except 9→0.
- Load: load=1 with load_val≤9 sets nxt=load_val, whatever en is.
- Invalid load: load=1 with load_val>9 is ignored. nxt=count, s=r=0, err is set.
- Hold: en=0 and load=0 gives nxt=count and s=r=0.
- Excitation is registered every posedge, per bit i:
  - s[i] <= nxt[i] & ~count[i]
  - r[i] <= ~nxt[i] & count[i]
  - count <= nxt
  - s[i] and r[i] are never both 1. Bits that do not change get 00, which is the SR hold code.
- tc: registered. High for exactly one cycle on a step whose nxt is lower than count: 8→0, 9→1, or 9→0. A load never raises tc, even if the loaded value is lower.
- wrap_cnt increments on each tc and wraps from 2^WRAP_W−1 to 0.
- err stays set until rst. No other event clears it.

## Timing
- Posedge t: s/r/count update.
- Negedge t+½: SR bank applies s/r.
- Posedge t+1: q_fb equals count.
- Latency from en sampled to count updated: 1 cycle. To SR bank q: 1.5 cycles.
- s/r are one-cycle pulses. They return to 0 on the next posedge unless another step occurs.
- Back-to-back en=1 advances one step per cycle with no bubbles.
- mode is sampled at the same posedge as en. A change on the step edge applies the mismatch rule to that step.
- rst asserted mid-operation clears every output immediately, asynchronously. The first posedge after release sees count=0.
- load and en together: load wins, and that edge performs no step.

## Configuration
- FB_CHECK_EN defined:
  - At every posedge, if q_fb ≠ count, err is set.
  - The compare is suppressed on the first posedge after rst release.
- FB_CHECK_EN undefined:
  - q_fb is unused.
  - err is set only by invalid loads.
  - The port list is the same in both builds.

## Test plan
- Reset, mode=0, en=1 for 6 cycles → count 2,4,6,8,0,2. tc high only in the cycle count becomes 0. wrap_cnt=1. s/r on the 8→0 step: s=0000, r=1000.
- Reset, mode=1, en=1 → count 1,3,5,7,9,1. tc on 9→1. s/r on 9→1: s=0000, r=1000.
- count=4, mode switches to 1 with en=1 → 5,7,9. count=9, switch mode to 0 → 0 with tc=1, then 2.
- load=1, load_val=7, en=1 → count=7, tc=0, s=0111. Then load_val=12 → count holds 7, s=r=0000, err=1 and remains 1.
- With FB_CHECK_EN, force q_fb[2] wrong for one cycle → err=1 at that posedge. Without FB_CHECK_EN, the same stimulus leaves err=0.
- Assert rst while count=6 mid-step → s, r, count, tc, wrap_cnt and err all 0 asynchronously. Counting restarts from 0 after release.
